// File: rtl/vga_timing_scroll_gen_if.sv
// vga_timing_scroll_gen_if
//   Bundles the timing generator's scroll controls and video timing outputs.
//   master : the timing generator (drives sync/blanking/coords/offset,
//            receives scroll_en/scroll_dir)
//   slave  : the consumer (pattern stage or bench)
interface vga_timing_scroll_gen_if;
  logic       scroll_en;
  logic       scroll_dir;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       line_start;
  logic       frame_start;
  logic [9:0] scroll_offset;

  modport master (
    input  scroll_en, scroll_dir,
    output hsync, vsync, display_on, hpos, vpos,
           line_start, frame_start, scroll_offset
  );

  modport slave (
    output scroll_en, scroll_dir,
    input  hsync, vsync, display_on, hpos, vpos,
           line_start, frame_start, scroll_offset
  );
endinterface

// File: rtl/vga_timing_scroll_gen.sv
// vga_timing_scroll_gen
//   Pixel-clock video timing generator (640x480@60 by default) with a
//   per-frame horizontal scroll offset kept in the pixel clock domain.
// Ports:
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   vif   : master side of vga_timing_scroll_gen_if
//           in  scroll_en, scroll_dir
//           out hsync, vsync, display_on, hpos, vpos, line_start,
//               frame_start, scroll_offset (all registered)
module vga_timing_scroll_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int SCROLL_STEP     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_timing_scroll_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [10:0] SC_MOD  = 11'(H_ACTIVE);
  localparam logic [10:0] SC_UP   = 11'(SCROLL_STEP);
  localparam logic [10:0] SC_DOWN = 11'(H_ACTIVE - SCROLL_STEP);

  // XOR mask turning an "asserted" flag into the pin level
  localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  logic [9:0]  r_hpos;
  logic [9:0]  r_vpos;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_display_on;
  logic        r_line_start;
  logic        r_frame_start;
  logic [9:0]  r_scroll;

  logic        w_h_wrap;
  logic        w_frame_wrap;
  logic [9:0]  w_hpos_nxt;
  logic [9:0]  w_vpos_nxt;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_de_nxt;
  logic [10:0] w_scroll_sum;
  logic [9:0]  w_scroll_nxt;

  assign w_h_wrap     = (r_hpos == H_LAST);
  assign w_frame_wrap = w_h_wrap && (r_vpos == V_LAST);

  assign w_hpos_nxt = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
  assign w_vpos_nxt = !w_h_wrap          ? r_vpos :
                      (r_vpos == V_LAST) ? 10'd0  : r_vpos + 10'd1;

  // Decode from the next counter values so every registered output lines
  // up with the hpos/vpos shown in the same cycle.
  assign w_hs_act = (w_hpos_nxt >= HS_START) && (w_hpos_nxt < HS_END);
  assign w_vs_act = (w_vpos_nxt >= VS_START) && (w_vpos_nxt < VS_END);
  assign w_de_nxt = (w_hpos_nxt < H_ACT) && (w_vpos_nxt < V_ACT);

  // Decrement is done as an add of (H_ACTIVE - step) so a single
  // conditional subtract keeps the result in 0..H_ACTIVE-1.
  assign w_scroll_sum = {1'b0, r_scroll} + (vif.scroll_dir ? SC_DOWN : SC_UP);
  assign w_scroll_nxt = (w_scroll_sum >= SC_MOD) ? 10'(w_scroll_sum - SC_MOD)
                                                 : w_scroll_sum[9:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos        <= 10'd0;
      r_vpos        <= 10'd0;
      r_hsync       <= SYNC_INV;
      r_vsync       <= SYNC_INV;
      r_display_on  <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_scroll      <= 10'd0;
    end else begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_hsync       <= w_hs_act ^ SYNC_INV;
      r_vsync       <= w_vs_act ^ SYNC_INV;
      r_display_on  <= w_de_nxt;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap && vif.scroll_en) begin
        r_scroll <= w_scroll_nxt;
      end
    end
  end

  assign vif.hpos          = r_hpos;
  assign vif.vpos          = r_vpos;
  assign vif.hsync         = r_hsync;
  assign vif.vsync         = r_vsync;
  assign vif.display_on    = r_display_on;
  assign vif.line_start    = r_line_start;
  assign vif.frame_start   = r_frame_start;
  assign vif.scroll_offset = r_scroll;

endmodule

// File: tb/tb_vga_timing_scroll_gen.sv
// tb_vga_timing_scroll_gen
//   Drives a default-parameter instance (640x480) and a shrunken instance
//   (28x10 total, step 3 over 20 columns) from the same stimulus and compares
//   both, every cycle, against an arithmetic model based on elapsed clocks.
module tb_vga_timing_scroll_gen;

  localparam int S_HA = 20, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_STEP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;   // 28
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;   // 10
  localparam int S_FRAME = S_HT * S_VT;                // 280
  localparam int B_FRAME = 800 * 525;

  logic clk = 1'b0;
  logic rst_n;
  logic scroll_en;
  logic scroll_dir;

  always #5 clk = ~clk;

  vga_timing_scroll_gen_if big_if ();
  vga_timing_scroll_gen_if small_if ();

  assign big_if.scroll_en    = scroll_en;
  assign big_if.scroll_dir   = scroll_dir;
  assign small_if.scroll_en  = scroll_en;
  assign small_if.scroll_dir = scroll_dir;

  vga_timing_scroll_gen u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (big_if.master)
  );

  vga_timing_scroll_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_ACTIVE_LOW(1), .SCROLL_STEP(S_STEP)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (small_if.master)
  );

  wire [34:0] big_obs = {big_if.hsync, big_if.vsync, big_if.display_on,
                         big_if.line_start, big_if.frame_start, big_if.hpos,
                         big_if.vpos, big_if.scroll_offset};
  wire [34:0] small_obs = {small_if.hsync, small_if.vsync, small_if.display_on,
                           small_if.line_start, small_if.frame_start, small_if.hpos,
                           small_if.vpos, small_if.scroll_offset};

  int total = 0;
  int bad   = 0;
  int t;          // active clock edges since reset was last sampled low
  int off_big;
  int off_small;

  // Expected outputs after t clocks of free running, for a given geometry.
  function automatic logic [34:0] ref_vec(int tc, int ha, int hfp, int hsw, int hbp,
                                          int va, int vfp, int vsw, int vbp, int off);
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int h  = tc % ht;
    int v  = (tc / ht) % vt;
    logic hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    logic vs = !((v >= va + vfp) && (v < va + vfp + vsw));
    logic de = (h < ha) && (v < va);
    logic ls = (tc != 0) && (h == 0);
    logic fs = ls && (v == 0);
    return {hs, vs, de, ls, fs, 10'(h), 10'(v), 10'(off)};
  endfunction

  function automatic int next_off(int off, int ha, int step, logic dir);
    return dir ? (off + ha - step) % ha : (off + step) % ha;
  endfunction

  task automatic chk(string tag, logic [34:0] obs, logic [34:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
    if (bad > 40) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  // One clock: advance the model with the inputs the DUT sees at this edge,
  // then compare both instances on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      t = 0; off_big = 0; off_small = 0;
    end else begin
      t++;
      if (scroll_en && (t % S_FRAME == 0)) off_small = next_off(off_small, S_HA, S_STEP, scroll_dir);
      if (scroll_en && (t % B_FRAME == 0)) off_big = next_off(off_big, 640, 5, scroll_dir);
    end
    @(negedge clk);
    chk("big_cycle", big_obs, ref_vec(t, 640, 16, 96, 48, 480, 10, 2, 33, off_big));
    chk("small_cycle", small_obs,
        ref_vec(t, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, off_small));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_low, de_low, fs_cnt, vs_low, n;
    rst_n = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
    t = 0; off_big = 0; off_small = 0;

    repeat (3) step();
    chk("rst_hpos",    35'(big_if.hpos), 35'(0));
    chk("rst_vpos",    35'(big_if.vpos), 35'(0));
    chk("rst_hsync",   35'(big_if.hsync), 35'(1));
    chk("rst_vsync",   35'(big_if.vsync), 35'(1));
    chk("rst_de",      35'(big_if.display_on), 35'(1));
    chk("rst_fs",      35'(big_if.frame_start), 35'(0));

    // Two 640-wide lines; small instance covers several whole frames.
    rst_n = 1'b1;
    hs_low = 0; de_low = 0; fs_cnt = 0; vs_low = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (t < 800 && !big_if.hsync) hs_low++;
      if (t < 800 && !big_if.display_on) de_low++;
      if (t == 656) chk("hsync_first_low", 35'(big_if.hsync), 35'(0));
      if (t == 752) chk("hsync_first_high", 35'(big_if.hsync), 35'(1));
      if (t == 800) begin
        chk("line1_vpos", 35'(big_if.vpos), 35'(1));
        chk("line1_hpos", 35'(big_if.hpos), 35'(0));
        chk("line1_ls",   35'(big_if.line_start), 35'(1));
      end
      if (small_if.frame_start) fs_cnt++;
      if (t == S_FRAME) chk("small_fs_at_frame", 35'(small_if.frame_start), 35'(1));
      if (t < S_FRAME && !small_if.vsync) vs_low++;
    end
    chk("hsync_low_count", 35'(hs_low), 35'(96));
    chk("de_low_count",    35'(de_low), 35'(160));
    chk("small_fs_count",  35'(fs_cnt), 35'(1600 / S_FRAME));
    chk("small_vs_low",    35'(vs_low), 35'(S_VS * S_HT));

    // Scroll up for 130 frames.
    pulse_reset();
    scroll_en = 1'b1; scroll_dir = 1'b0;
    repeat (S_FRAME) step();
    chk("up_1", 35'(small_if.scroll_offset), 35'(S_STEP));
    repeat (129 * S_FRAME) step();
    chk("up_130", 35'(small_if.scroll_offset), 35'((130 * S_STEP) % S_HA));

    // Scroll down from zero, then freeze.
    pulse_reset();
    scroll_dir = 1'b1;
    repeat (S_FRAME) step();
    chk("down_1", 35'(small_if.scroll_offset), 35'(S_HA - S_STEP));
    repeat (S_FRAME) step();
    chk("down_2", 35'(small_if.scroll_offset), 35'(S_HA - 2 * S_STEP));
    scroll_en = 1'b0;
    repeat (3 * S_FRAME) step();
    chk("frozen", 35'(small_if.scroll_offset), 35'(S_HA - 2 * S_STEP));

    // Mid-frame change only takes effect at the next wrap.
    repeat (2 * S_HT + 5) step();
    scroll_en = 1'b1; scroll_dir = 1'b0;
    n = 0;
    while ((t % S_FRAME) != S_FRAME - 1 && n < 400) begin step(); n++; end
    chk("mid_hold", 35'(small_if.scroll_offset), 35'(S_HA - 2 * S_STEP));
    step();
    chk("mid_apply", 35'(small_if.scroll_offset), 35'(S_HA - S_STEP));

    // Single-clock reset in the middle of a frame.
    n = 0;
    while (!(small_if.vpos == 10'd5 && small_if.hpos == 10'd10) && n < 400) begin step(); n++; end
    chk("reach_mid", 35'(small_if.hpos), 35'(10));
    pulse_reset();
    chk("mid_rst_hpos", 35'(small_if.hpos), 35'(0));
    chk("mid_rst_off",  35'(small_if.scroll_offset), 35'(0));
    chk("mid_rst_hs",   35'(small_if.hsync), 35'(1));
    chk("mid_rst_fs",   35'(small_if.frame_start), 35'(0));
    n = 0;
    do begin step(); n++; end while (!small_if.frame_start && n < 400);
    chk("fs_after_rst", 35'(n), 35'(S_FRAME));

    // Randomised scroll settings and occasional resets.
    for (int k = 0; k < 60; k++) begin
      scroll_en  = 1'($urandom_range(0, 1));
      scroll_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) pulse_reset();
      repeat ($urandom_range(1, 300)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
